// File: rtl/line_delay_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : line_delay_ctrl_if
// Purpose  : Bundles the control/status signals between the camera capture
//            stage (master) and the line-delay controller (slave).
// Ports    : cfg_load_i/cfg_width_i  - width configuration strobe + value
//            frame_start_i/stop_i    - frame sequencing strobes
//            pix_valid_i/line_end_i  - pixel stream qualifiers
//            fifo_enable_o/size_o    - drive the programmable FIFO
//            out_valid_o/primed_o    - delayed-line validity
//            col_o/line_o            - position of the next pixel
//            cfg_err_o/sync_err_o    - configuration / line-length errors
//            busy_o                  - controller not idle
// Revision : 1.0 - initial release
// ============================================================================
interface line_delay_ctrl_if #(
  parameter int SIZE_W = 16,
  parameter int LINE_W = 12
);
  logic              cfg_load_i;
  logic [SIZE_W-1:0] cfg_width_i;
  logic              frame_start_i;
  logic              stop_i;
  logic              pix_valid_i;
  logic              line_end_i;
  logic              fifo_enable_o;
  logic [SIZE_W-1:0] fifo_size_o;
  logic              out_valid_o;
  logic              primed_o;
  logic [SIZE_W-1:0] col_o;
  logic [LINE_W-1:0] line_o;
  logic              cfg_err_o;
  logic              sync_err_o;
  logic              busy_o;

  modport slave (
    input  cfg_load_i, cfg_width_i, frame_start_i, stop_i, pix_valid_i, line_end_i,
    output fifo_enable_o, fifo_size_o, out_valid_o, primed_o, col_o, line_o,
           cfg_err_o, sync_err_o, busy_o
  );

  modport master (
    output cfg_load_i, cfg_width_i, frame_start_i, stop_i, pix_valid_i, line_end_i,
    input  fifo_enable_o, fifo_size_o, out_valid_o, primed_o, col_o, line_o,
           cfg_err_o, sync_err_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/line_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : line_delay_ctrl
// Purpose  : Sequences and configures the programmable line-delay FIFO.
//            Latches the line width, gates the FIFO enable with pixel valids,
//            tracks fill/column/line position and flags when the FIFO output
//            holds a valid previous-line pixel.
// Ports    : clk, reset (synchronous, active-high)
//            bus                 - line_delay_ctrl_if.slave
//            frame_count_o       - frames started      (STATS only)
//            short_line_count_o  - line-length errors  (STATS only)
// Options  : LINE_DELAY_CTRL_STATS_EN adds the two statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
module line_delay_ctrl #(
  parameter int MAX_SIZE     = 1024,
  parameter int SIZE_W       = 16,
  parameter int DEFAULT_SIZE = 640,
  parameter int LINE_W       = 12
) (
  input  logic               clk,
  input  logic               reset,
  line_delay_ctrl_if.slave   bus
`ifdef LINE_DELAY_CTRL_STATS_EN
  ,
  output logic [15:0]        frame_count_o,
  output logic [7:0]         short_line_count_o
`endif
);

  localparam logic [SIZE_W-1:0] C_MAX_SIZE     = SIZE_W'(MAX_SIZE);
  localparam logic [SIZE_W-1:0] C_DEFAULT_SIZE = SIZE_W'(DEFAULT_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SIZE_W-1:0] fifo_size_q, fifo_size_d;
  logic [SIZE_W-1:0] col_q, col_d;
  logic [SIZE_W-1:0] fill_q, fill_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              primed_q, primed_d;
  logic              out_valid_q, out_valid_d;
  logic              cfg_err_q, cfg_err_d;
  logic              sync_err_q, sync_err_d;

  logic              w_cfg_ok;
  logic              w_start;
  logic              w_en;
  logic              w_sync_evt;
  logic [SIZE_W-1:0] w_size_m1;
  logic [SIZE_W-1:0] w_fill_inc;

  // Enable may open in IDLE too, when frame_start arrives with a pixel:
  // that pixel is pixel 0 of the new frame.
  assign w_en = bus.pix_valid_i & ~bus.stop_i & ~reset &
                ((state_q != IDLE) | bus.frame_start_i);

  always_comb begin
    w_cfg_ok    = bus.cfg_load_i && (state_q == IDLE) &&
                  (bus.cfg_width_i != '0) && (bus.cfg_width_i <= C_MAX_SIZE);
    w_start     = bus.frame_start_i & ~bus.stop_i;
    // A width accepted this cycle already governs a frame starting this cycle.
    fifo_size_d = w_cfg_ok ? bus.cfg_width_i : fifo_size_q;
    w_size_m1   = fifo_size_d - SIZE_W'(1);
    w_fill_inc  = '0;
    w_sync_evt  = 1'b0;

    state_d     = state_q;
    col_d       = col_q;
    fill_d      = fill_q;
    line_d      = line_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    cfg_err_d   = bus.cfg_load_i & ~w_cfg_ok;
    sync_err_d  = w_cfg_ok ? 1'b0 : sync_err_q;

    if (bus.stop_i) begin
      state_d  = IDLE;
      col_d    = '0;
      line_d   = '0;
      fill_d   = '0;
      primed_d = 1'b0;
    end else begin
      if (w_start) begin
        state_d  = FILL;
        col_d    = '0;
        line_d   = '0;
        fill_d   = '0;
        primed_d = 1'b0;
      end

      // Delayed output is only meaningful once the FIFO holds a full line.
      out_valid_d = (state_q == RUN) & ~w_start & w_en;

      if (w_en) begin
        if (state_d == FILL) begin
          w_fill_inc = fill_d + SIZE_W'(1);
          fill_d     = w_fill_inc;
          if (w_fill_inc == fifo_size_d) begin
            primed_d = 1'b1;
            state_d  = RUN;
          end
        end

        if (bus.line_end_i && (col_d != w_size_m1)) begin
          // Early line end: resynchronise column to the new line.
          w_sync_evt = 1'b1;
          col_d      = '0;
          line_d     = line_d + LINE_W'(1);
        end else if (col_d == w_size_m1) begin
          col_d  = '0;
          line_d = line_d + LINE_W'(1);
        end else begin
          col_d = col_d + SIZE_W'(1);
        end
      end
    end

    if (w_sync_evt) sync_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fifo_size_q <= C_DEFAULT_SIZE;
      col_q       <= '0;
      fill_q      <= '0;
      line_q      <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_size_q <= fifo_size_d;
      col_q       <= col_d;
      fill_q      <= fill_d;
      line_q      <= line_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign bus.fifo_enable_o = w_en;
  assign bus.fifo_size_o   = fifo_size_q;
  assign bus.out_valid_o   = out_valid_q;
  assign bus.primed_o      = primed_q;
  assign bus.col_o         = col_q;
  assign bus.line_o        = line_q;
  assign bus.cfg_err_o     = cfg_err_q;
  assign bus.sync_err_o    = sync_err_q;
  assign bus.busy_o        = (state_q != IDLE);

`ifdef LINE_DELAY_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  short_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      short_cnt_q <= '0;
    end else begin
      if (w_start) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (w_sync_evt && (short_cnt_q != 8'hFF)) short_cnt_q <= short_cnt_q + 8'd1;
    end
  end

  assign frame_count_o      = frame_cnt_q;
  assign short_line_count_o = short_cnt_q;
`endif

endmodule
`default_nettype wire
